// File: rtl/seq_mult_6bit.sv
// Sequential unsigned shift-and-add multiplier. It time-shares an external WIDTH-bit ripple adder
// and handles one partial product per clock, with a start/busy/done handshake to the controller.
module seq_mult_6bit #(
   parameter int unsigned WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic                 add_cin,
   input  logic [WIDTH-1:0]     add_s,
   input  logic                 add_cout
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    acc, acc_nxt;
   logic [WIDTH-1:0]    mq, mq_nxt;
   logic [WIDTH-1:0]    mc, mc_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                busy_nxt, done_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath next values, flag next values and adder drive
   always_comb begin
      acc_nxt  = acc;
      mq_nxt   = mq;
      mc_nxt   = mc;
      cnt_nxt  = cnt;
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               mc_nxt  = mcand;
               mq_nxt  = mplier;
               acc_nxt = '0;
               cnt_nxt = '0;
            end
         end
         RUN: begin
            add_a   = acc;
            add_b   = mq[0] ? mc : '0;
            // {cout,s,mq} shifted right one place: the carry lands in the top bit of acc
            acc_nxt = {add_cout, add_s[WIDTH-1:1]};
            mq_nxt  = {add_s[0], mq[WIDTH-1:1]};
            cnt_nxt = cnt + CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Datapath and registered handshake flags
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         mq   <= '0;
         mc   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         acc  <= acc_nxt;
         mq   <= mq_nxt;
         mc   <= mc_nxt;
         cnt  <= cnt_nxt;
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   assign product = {acc, mq};

endmodule
